// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Stall/flush sequencer for a 5-stage RISC-V pipeline. It handles the hazards
// the forwarding unit cannot: load-use hazards (one bubble), control redirects
// resolved in EX (squash IF/ID and ID/EX), and multi-cycle data-memory waits
// (freeze the whole pipe, with a timeout that force-releases a stuck access).
// Two saturating performance counters track stall and redirect cycles.
//
// Ports:
//   clk, rst_n          pipeline clock, synchronous active-low reset
//   id_rs1/id_rs2       source registers of the ID instruction
//   id_use_rs1/2        ID instruction actually reads rs1/rs2
//   ex_rd, ex_reg_we    EX destination register and its write enable
//   ex_mem_read         EX instruction is a load
//   ex_jump_t           EX jump type: 01 JAL, 10 JALR, 00/11 no jump
//   ex_branch_taken     EX conditional branch resolved taken
//   mem_req, mem_ready  MEM-stage access pending / completing this cycle
//   pc_we .. ex_mem_we  pipeline register enables (combinational)
//   *_flush             pipeline register clears to NOP/bubble
//   mem_err             sticky memory-wait timeout flag
//   stall_cnt           saturating count of stall cycles
//   flush_cnt           saturating count of redirect cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_we,
    input  logic             ex_mem_read,
    input  logic [1:0]       ex_jump_t,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_cnt_next;
    logic                r_mem_err;

    logic                w_redirect;
    logic                w_load_use;
    logic                w_timeout_now;
    logic                w_freeze;
    logic [1:0]          w_cnt_inc;

    // Hazard terms
    assign w_redirect = (ex_jump_t == 2'b01) || (ex_jump_t == 2'b10) || ex_branch_taken;

    assign w_load_use = ex_mem_read && ex_reg_we && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    // The cycle whose wait_cnt reaches MEM_TIMEOUT-1 is released regardless of
    // mem_ready, which caps a single access at MEM_TIMEOUT-1 freeze cycles.
    assign w_timeout_now = (r_state == ST_MEM_WAIT) &&
                           (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    assign w_freeze = mem_req && !mem_ready && !w_timeout_now;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_timeout_now && mem_req && !mem_ready) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next    = ST_RUN;
        w_wait_cnt_next = '0;
        if (w_freeze) begin
            w_state_next = ST_MEM_WAIT;
            if (r_state == ST_RUN) begin
                w_wait_cnt_next = WAIT_W'(1);
            end else begin
                w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Mealy pipeline controls. Freeze wins over redirect because EX is held
    // during a freeze, so the redirect is still present on the first unfrozen
    // cycle. Redirect wins over load-use since the ID instruction is squashed.
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst_n) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (w_freeze) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (w_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID; ID/EX loads a bubble while the load advances.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    // Saturating performance counters: index 0 stalls, index 1 redirects.
    assign w_cnt_inc[0] = w_freeze || (w_load_use && !w_redirect);
    assign w_cnt_inc[1] = w_redirect && !w_freeze;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc[gi] && !(&r_cnt)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_cnt = g_perf[0].r_cnt;
    assign flush_cnt = g_perf[1].r_cnt;
    assign mem_err   = r_mem_err;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve: load-use hazards, control redirects resolved in EX, and multi-cycle data-memory waits. It drives the write-enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also contains a memory-wait timeout and saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, cycle index at which a pending memory wait is force-released; legal range ≥2.
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
rst_n  in  1  synchronous, active-low reset.
id_rs1  in  5  rs1 of the instruction in ID.
id_rs2  in  5  rs2 of the instruction in ID.
id_use_rs1  in  1  ID instruction reads rs1.
id_use_rs2  in  1  ID instruction reads rs2.
ex_rd  in  5  destination register of the instruction in EX.
ex_reg_we  in  1  EX instruction writes the register file.
ex_mem_read  in  1  EX instruction is a load.
ex_jump_t  in  2  EX jump type: 00 NO_JUMP, 01 JAL, 10 JAL_R, 11 reserved (treated as NO_JUMP).
ex_branch_taken  in  1  EX conditional branch resolved taken.
mem_req  in  1  MEM stage has an active data-memory access.
mem_ready  in  1  data memory completes the access this cycle.
pc_we  out  1  PC update enable.
if_id_we  out  1  IF/ID register enable.
if_id_flush  out  1  IF/ID clear to NOP.
id_ex_we  out  1  ID/EX register enable.
id_ex_flush  out  1  ID/EX clear to NOP.
ex_mem_we  out  1  EX/MEM register enable.
mem_wb_flush  out  1  MEM/WB loads a bubble.
mem_err  out  1  sticky flag: a memory-wait timeout has occurred.
stall_cnt  out  CNT_W  count of stall cycles, saturating.
flush_cnt  out  CNT_W  count of redirect cycles, saturating.

Behaviour:
- Reset: on a clk edge with rst_n=0, state←RUN, wait_cnt←0, mem_err←0, stall_cnt←0, flush_cnt←0.
- While rst_n=0, the combinational outputs are forced to: pc_we=if_id_we=id_ex_we=ex_mem_we=0, and if_id_flush=id_ex_flush=mem_wb_flush=1.
- State machine: two states, RUN and MEM_WAIT, plus an internal wait_cnt of width clog2(MEM_TIMEOUT)+1.
- Derived terms:
  - redirect = (ex_jump_t==01 | ex_jump_t==10 | ex_branch_taken)
  - load_use = ex_mem_read & ex_reg_we & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
  - timeout_now = (state==MEM_WAIT & wait_cnt==MEM_TIMEOUT-1)
  - freeze = mem_req & !mem_ready & !timeout_now
- Outputs are Mealy (combinational, same cycle). They resolve in priority order; the first matching rule applies:
  1. freeze: all four enables=0; if_id_flush=id_ex_flush=0; mem_wb_flush=1.
  2. redirect: all enables=1; if_id_flush=id_ex_flush=1; mem_wb_flush=0.
  3. load_use: pc_we=0, if_id_we=0; id_ex_we=1 with id_ex_flush=1 (one bubble); ex_mem_we=1; if_id_flush=0; mem_wb_flush=0.
  4. Otherwise: all enables=1, all flushes=0.
- A redirect arriving during freeze is held, not lost: EX is frozen, so it is honoured on the first unfrozen cycle. Redirect beats load_use because the ID instruction is on the wrong path.
- Transitions:
  - RUN→MEM_WAIT when freeze; wait_cnt←1.
  - MEM_WAIT→MEM_WAIT when freeze; wait_cnt←wait_cnt+1.
  - MEM_WAIT→RUN when !freeze; wait_cnt←0.
  - When timeout_now & mem_req & !mem_ready: mem_err←1 and the pipeline is released that cycle.
- Timeout bound: at most MEM_TIMEOUT-1 consecutive freeze cycles occur per access.
- mem_err stays at 1 until reset. Later waits behave normally.
- Counters:
  - stall_cnt += 1 on each cycle where freeze | (load_use & !redirect).
  - flush_cnt += 1 on each unfrozen redirect cycle.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Latency: zero cycles from inputs to enables and flushes. State and counters update on the following edge.

Test Plan:
1. Load x5 in EX (ex_mem_read=1, ex_reg_we=1, ex_rd=5); ID has id_rs1=5, id_use_rs1=1 → that cycle pc_we=0, if_id_we=0, id_ex_flush=1; next cycle with a non-load in EX all enables=1; stall_cnt=1.
2. Same as scenario 1 with ex_rd=0, or with id_use_rs1=0 → no stall; all enables=1; stall_cnt stays 0.
3. ex_jump_t=10 concurrent with a load_use condition → if_id_flush=id_ex_flush=1, pc_we=1; flush_cnt=1; stall_cnt=0.
4. mem_req=1, mem_ready=0 for 3 cycles, then 1 → 3 cycles with all enables=0 and mem_wb_flush=1; released on cycle 4; stall_cnt=3; mem_err=0; state returns to RUN.
5. MEM_TIMEOUT=4, mem_ready held at 0 → 3 freeze cycles; on cycle 4 enables=1 and mem_err→1 and stays 1; ex_branch_taken held during the freeze → flush on the release cycle.
6. CNT_W=2, 5 load_use stalls → stall_cnt=3 (saturated). Assert rst_n=0 mid-MEM_WAIT → outputs forced to reset values that cycle; after the edge, state=RUN and all counters and mem_err read 0.
